// File: rtl/microcode_pkg.sv
// Shared definitions for the microcode sequencer of the 8-bit bus computer.
// Contents: control-word width, control-bit indices (HLT_B = bit 15 down to FI_B = bit 0),
// opcode values, and a helper that turns a bit index into a one-hot control word.
package microcode_pkg;

  localparam int unsigned CTRL_W = 16;

  // Control-word bit positions
  localparam int unsigned HLT_B = 15;
  localparam int unsigned MI_B  = 14;
  localparam int unsigned RI_B  = 13;
  localparam int unsigned RO_B  = 12;
  localparam int unsigned IO_B  = 11;
  localparam int unsigned II_B  = 10;
  localparam int unsigned AI_B  = 9;
  localparam int unsigned AO_B  = 8;
  localparam int unsigned EO_B  = 7;
  localparam int unsigned SU_B  = 6;
  localparam int unsigned BI_B  = 5;
  localparam int unsigned OI_B  = 4;
  localparam int unsigned CE_B  = 3;
  localparam int unsigned CO_B  = 2;
  localparam int unsigned J_B   = 1;
  localparam int unsigned FI_B  = 0;

  // Opcodes
  localparam int unsigned OP_NOP = 0;
  localparam int unsigned OP_LDA = 1;
  localparam int unsigned OP_ADD = 2;
  localparam int unsigned OP_SUB = 3;
  localparam int unsigned OP_STA = 4;
  localparam int unsigned OP_LDI = 5;
  localparam int unsigned OP_JMP = 6;
  localparam int unsigned OP_JC  = 7;
  localparam int unsigned OP_JZ  = 8;
  localparam int unsigned OP_OUT = 14;
  localparam int unsigned OP_HLT = 15;

  function automatic logic [CTRL_W-1:0] cbit(input int unsigned b);
    return CTRL_W'(1) << b;
  endfunction

endpackage

// File: rtl/microcode_rom.sv
// Combinational microcode decoder: (opcode, step, carry flag, zero flag) -> control word.
// Ports:
//   opcode_i  OPCODE_WIDTH-bit opcode from the IR
//   step_i    current T-state
//   carry_i   registered carry flag
//   zero_i    registered zero flag
//   ctrl_o    16-bit control word (HLT = bit 15 ... FI = bit 0)
module microcode_rom
  import microcode_pkg::*;
#(
  parameter int unsigned OPCODE_WIDTH = 4,
  parameter int unsigned MAX_STEPS    = 5,
  parameter int unsigned STEP_W       = 3
) (
  input  logic [OPCODE_WIDTH-1:0] opcode_i,
  input  logic [STEP_W-1:0]       step_i,
  input  logic                    carry_i,
  input  logic                    zero_i,
  output logic [CTRL_W-1:0]       ctrl_o
);

  logic [31:0] op;
  logic [31:0] t;

  always_comb begin
    ctrl_o = '0;
    op     = 32'(opcode_i);
    t      = 32'(step_i);
    // Steps beyond the configured depth never issue anything
    if (t < MAX_STEPS) begin
      case (t)
        0: ctrl_o = cbit(CO_B) | cbit(MI_B);
        1: ctrl_o = cbit(RO_B) | cbit(II_B) | cbit(CE_B);
        2: begin
          case (op)
            OP_LDA, OP_ADD, OP_SUB, OP_STA: ctrl_o = cbit(IO_B) | cbit(MI_B);
            OP_LDI: ctrl_o = cbit(IO_B) | cbit(AI_B);
            OP_JMP: ctrl_o = cbit(IO_B) | cbit(J_B);
            OP_JC:  ctrl_o = carry_i ? (cbit(IO_B) | cbit(J_B)) : '0;
            OP_JZ:  ctrl_o = zero_i ? (cbit(IO_B) | cbit(J_B)) : '0;
            OP_OUT: ctrl_o = cbit(AO_B) | cbit(OI_B);
            OP_HLT: ctrl_o = cbit(HLT_B);
            default: ctrl_o = '0;
          endcase
        end
        3: begin
          case (op)
            OP_LDA:         ctrl_o = cbit(RO_B) | cbit(AI_B);
            OP_ADD, OP_SUB: ctrl_o = cbit(RO_B) | cbit(BI_B);
            OP_STA:         ctrl_o = cbit(AO_B) | cbit(RI_B);
            default:        ctrl_o = '0;
          endcase
        end
        4: begin
          case (op)
            OP_ADD:  ctrl_o = cbit(EO_B) | cbit(AI_B) | cbit(FI_B);
            OP_SUB:  ctrl_o = cbit(EO_B) | cbit(AI_B) | cbit(SU_B) | cbit(FI_B);
            default: ctrl_o = '0;
          endcase
        end
        default: ctrl_o = '0;
      endcase
    end
  end

endmodule

// File: rtl/microcode_sequencer.sv
// Control unit for the 8-bit bus computer: instruction register, T-step counter, flags
// register and halt latch around the microcode_rom decoder.
// Optional feature (macro MICROCODE_SEQUENCER_EARLY_END_EN): when defined, an all-zero control
// word at step >= 2 restarts the fetch on that step_en instead of idling to MAX_STEPS-1.
// Ports:
//   clk         system clock
//   rst_n       synchronous active-low reset
//   step_en     one-cycle advance strobe; state only moves while it is high
//   bus_in      shared bus value (loaded into IR on II)
//   carry_in    ALU carry (captured on FI)
//   zero_in     ALU zero (captured on FI)
//   ctrl        combinational control word (HLT = bit 15 ... FI = bit 0)
//   ir_bus_out  IR operand, zero-extended
//   step        current T-state
//   halted      halt latched
module microcode_sequencer
  import microcode_pkg::*;
#(
  parameter int unsigned DATA_WIDTH   = 8,
  parameter int unsigned OPCODE_WIDTH = 4,
  parameter int unsigned MAX_STEPS    = 5,
  localparam int unsigned STEP_W      = (MAX_STEPS > 1) ? $clog2(MAX_STEPS) : 1
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  step_en,
  input  logic [DATA_WIDTH-1:0] bus_in,
  input  logic                  carry_in,
  input  logic                  zero_in,
  output logic [CTRL_W-1:0]     ctrl,
  output logic [DATA_WIDTH-1:0] ir_bus_out,
  output logic [STEP_W-1:0]     step,
  output logic                  halted
);

  localparam int unsigned OPERAND_W = DATA_WIDTH - OPCODE_WIDTH;

  logic [DATA_WIDTH-1:0] ir_q, ir_d;
  logic [STEP_W-1:0]     step_q, step_d;
  logic [1:0]            flags_q, flags_d;  // {carry, zero}
  logic                  halted_q, halted_d;
  logic [CTRL_W-1:0]     rom_ctrl;

  microcode_rom #(
    .OPCODE_WIDTH (OPCODE_WIDTH),
    .MAX_STEPS    (MAX_STEPS),
    .STEP_W       (STEP_W)
  ) u_rom (
    .opcode_i (ir_q[DATA_WIDTH-1 -: OPCODE_WIDTH]),
    .step_i   (step_q),
    .carry_i  (flags_q[1]),
    .zero_i   (flags_q[0]),
    .ctrl_o   (rom_ctrl)
  );

  // Reset presents the T0 word immediately so the bus is never driven by stale microcode
  always_comb begin
    ctrl = rom_ctrl;
    if (!rst_n) begin
      ctrl = cbit(CO_B) | cbit(MI_B);
    end else if (halted_q) begin
      ctrl = cbit(HLT_B);
    end
  end

  always_comb begin
    ir_d     = ir_q;
    step_d   = step_q;
    flags_d  = flags_q;
    halted_d = halted_q;
    if (step_en && !halted_q) begin
      if (rom_ctrl[II_B]) ir_d = bus_in;
      if (rom_ctrl[FI_B]) flags_d = {carry_in, zero_in};
      if (rom_ctrl[HLT_B]) begin
        halted_d = 1'b1;
      end else begin
`ifdef MICROCODE_SEQUENCER_EARLY_END_EN
        if ((rom_ctrl == '0) && (32'(step_q) >= 2)) begin
          step_d = '0;
        end else if (step_q == STEP_W'(MAX_STEPS - 1)) begin
          step_d = '0;
        end else begin
          step_d = step_q + 1'b1;
        end
`else
        if (step_q == STEP_W'(MAX_STEPS - 1)) begin
          step_d = '0;
        end else begin
          step_d = step_q + 1'b1;
        end
`endif
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      ir_q     <= '0;
      step_q   <= '0;
      flags_q  <= '0;
      halted_q <= 1'b0;
    end else begin
      ir_q     <= ir_d;
      step_q   <= step_d;
      flags_q  <= flags_d;
      halted_q <= halted_d;
    end
  end

  assign ir_bus_out = {{OPCODE_WIDTH{1'b0}}, ir_q[OPERAND_W-1:0]};
  assign step       = step_q;
  assign halted     = halted_q;

endmodule
